// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: stage-5 writeback has priority, long-latency
// unit results queue in a small FIFO with a forced one-cycle drain against starvation.
module wb_port_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_wb_valid,
   input  logic [ADDR_W-1:0]        pipe_rd,
   input  logic [DATA_W-1:0]        pipe_data,
   input  logic                     lu_valid,
   input  logic [ADDR_W-1:0]        lu_rd,
   input  logic [DATA_W-1:0]        lu_data,
   output logic                     lu_ready,
   output logic                     stall_pipe,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned WC_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   localparam logic [0:0] NORMAL = 1'b0;
   localparam logic [0:0] STALL  = 1'b1;

   logic [0:0]        state;
   logic [WC_W-1:0]   wait_cnt;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] mem_rd   [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];

   logic              full;
   logic              empty;
   logic              enq;
   logic              grant_pipe;
   logic              grant_fifo;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign lu_ready   = ~full & ~rst;
   assign enq        = lu_valid & lu_ready;
   assign stall_pipe = (state == STALL);
   assign fifo_count = count;

   // STALL is only entered with a nonempty FIFO, so the empty guard never masks it.
   always_comb begin
      grant_pipe = (state == NORMAL) & pipe_wb_valid;
      grant_fifo = ~empty & ((state == STALL) | ~pipe_wb_valid);
      sel_rd     = grant_pipe ? pipe_rd   : mem_rd[rd_ptr];
      sel_data   = grant_pipe ? pipe_data : mem_data[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_rd[wr_ptr]   <= lu_rd;
         mem_data[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         state    <= NORMAL;
         wait_cnt <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (grant_fifo)
            rd_ptr <= rd_ptr + PTR_W'(1);

         case ({enq, grant_fifo})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // Remaining case is a pipe grant while an LU result waits.
         if (grant_fifo || empty) begin
            state    <= NORMAL;
            wait_cnt <= '0;
         end else if (wait_cnt == WC_W'(STARVE_LIMIT - 1)) begin
            state    <= STALL;
            wait_cnt <= '0;
         end else begin
            state    <= NORMAL;
            wait_cnt <= wait_cnt + WC_W'(1);
         end

         if (grant_pipe || grant_fifo) begin
            rf_we    <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
         end else begin
            rf_we    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// reset/full-FIFO sequences, and randomized traffic against a queue-based model.
module tb_wb_port_arbiter;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 5;
   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              pipe_wb_valid;
   logic [ADDR_W-1:0] pipe_rd;
   logic [DATA_W-1:0] pipe_data;
   logic              lu_valid;
   logic [ADDR_W-1:0] lu_rd;
   logic [DATA_W-1:0] lu_data;
   logic              lu_ready;
   logic              stall_pipe;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [$clog2(DEPTH):0] fifo_count;

   wb_port_arbiter #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH(DEPTH),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pipe_wb_valid(pipe_wb_valid),
      .pipe_rd(pipe_rd),
      .pipe_data(pipe_data),
      .lu_valid(lu_valid),
      .lu_rd(lu_rd),
      .lu_data(lu_data),
      .lu_ready(lu_ready),
      .stall_pipe(stall_pipe),
      .rf_we(rf_we),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      pipe_wb_valid = pv;
      pipe_rd       = prd;
      pipe_data     = pd;
      lu_valid      = lv;
      lu_rd         = lrd;
      lu_data       = ld;
   endtask

   typedef struct {
      logic pv; logic [4:0] prd; logic [31:0] pd;
      logic lv; logic [4:0] lrd; logic [31:0] ld;
      logic we; logic [4:0] wa;  logic [31:0] wd;
      logic st; logic [1:0] cnt; logic rdy;
   } vec_t;

   function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic st, input logic [1:0] cnt, input logic rdy);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.cnt = cnt; v.rdy = rdy;
      return v;
   endfunction

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];

   initial begin
      // Row: inputs applied for one cycle; expected outputs just after that edge.
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 1));
      vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 0, 1));
      vecs.push_back(mk(1, 0, 32'h11111111, 0, 0, 0,            0, 0, 32'h11111111, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0, 32'h11111111, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h12345678, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,            1, 3, 32'hA0,       0, 7, 32'h12345678, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,            1, 4, 32'hB0,       1, 3, 32'hA0,       0, 1, 1));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 4, 32'hB0,       0, 0, 1));
      vecs.push_back(mk(1, 1, 1,            1, 9, 32'h99,       1, 1, 1,            0, 1, 1));
      vecs.push_back(mk(1, 2, 2,            0, 0, 0,            1, 2, 2,            0, 1, 1));
      vecs.push_back(mk(1, 3, 3,            0, 0, 0,            1, 3, 3,            0, 1, 1));
      vecs.push_back(mk(1, 4, 4,            0, 0, 0,            1, 4, 4,            0, 1, 1));
      vecs.push_back(mk(1, 5, 5,            0, 0, 0,            1, 5, 5,            1, 1, 1));
      vecs.push_back(mk(1, 6, 6,            0, 0, 0,            1, 9, 32'h99,       0, 0, 1));
      vecs.push_back(mk(1, 6, 6,            0, 0, 0,            1, 6, 6,            0, 0, 1));
      vecs.push_back(mk(1, 10, 10,          1, 11, 32'h11,      1, 10, 10,          0, 1, 1));
      vecs.push_back(mk(1, 12, 12,          1, 13, 32'h13,      1, 12, 12,          0, 2, 0));
      vecs.push_back(mk(1, 14, 14,          1, 15, 32'h15,      1, 14, 14,          0, 2, 0));
      vecs.push_back(mk(1, 16, 16,          1, 15, 32'h15,      1, 16, 16,          0, 2, 0));
      vecs.push_back(mk(1, 17, 17,          1, 15, 32'h15,      1, 17, 17,          1, 2, 0));
      vecs.push_back(mk(1, 18, 18,          1, 15, 32'h15,      1, 11, 32'h11,      0, 1, 1));
      vecs.push_back(mk(1, 18, 18,          1, 15, 32'h15,      1, 18, 18,          0, 2, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 13, 32'h13,      0, 1, 1));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 15, 32'h15,      0, 0, 1));

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check("rst_we", rf_we, 0);
      check("rst_ready", lu_ready, 0);
      check("rst_count", fifo_count, 0);
      check("rst_stall", stall_pipe, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_ready", lu_ready, 1);

      // Directed vector table
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
         tick();
         check($sformatf("v%0d_we", i),    rf_we,      vecs[i].we);
         check($sformatf("v%0d_waddr", i), rf_waddr,   vecs[i].wa);
         check($sformatf("v%0d_wdata", i), rf_wdata,   vecs[i].wd);
         check($sformatf("v%0d_stall", i), stall_pipe, vecs[i].st);
         check($sformatf("v%0d_count", i), fifo_count, vecs[i].cnt);
         check($sformatf("v%0d_ready", i), lu_ready,   vecs[i].rdy);
      end

      // Full FIFO: head dequeues while lu_ready stays low, no bypass of the offered result
      drive(1, 0, 5, 1, 20, 32'h20);
      tick();
      check("full_fill1_count", fifo_count, 1);
      check("full_fill1_we", rf_we, 0);
      drive(1, 0, 5, 1, 21, 32'h21);
      tick();
      check("full_fill2_count", fifo_count, 2);
      check("full_fill2_ready", lu_ready, 0);
      drive(0, 0, 0, 1, 22, 32'h22);
      #1;
      check("full_deq_ready_pre", lu_ready, 0);
      tick();
      check("full_deq_we", rf_we, 1);
      check("full_deq_waddr", rf_waddr, 20);
      check("full_deq_wdata", rf_wdata, 32'h20);
      check("full_deq_count", fifo_count, 1);
      check("full_next_ready", lu_ready, 1);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check("full_drain_waddr", rf_waddr, 21);
      check("full_drain_count", fifo_count, 0);
      tick();
      check("full_no_dup_we", rf_we, 0);

      // Reset mid-stream with two queued LU results
      drive(1, 0, 0, 1, 25, 32'h25);
      tick();
      drive(1, 2, 32'hAB, 1, 26, 32'h26);
      tick();
      check("mrst_pre_count", fifo_count, 2);
      check("mrst_pre_we", rf_we, 1);
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_count", fifo_count, 0);
      check("mrst_ready", lu_ready, 0);
      check("mrst_we", rf_we, 0);
      check("mrst_waddr", rf_waddr, 0);
      check("mrst_stall", stall_pipe, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("mrst_after%0d_we", i), rf_we, 0);
         check($sformatf("mrst_after%0d_count", i), fifo_count, 0);
      end

      // Randomized traffic against a queue-based reference model
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      begin
         bit          m_stall = 0;
         int          m_wait  = 0;
         logic        e_we    = 0;
         logic [4:0]  e_wa    = 0;
         logic [31:0] e_wd    = 0;
         bit          lu_taken = 1;
         int          pprob;
         q.delete();
         drive(0, 0, 0, 0, 0, 0);
         for (int c = 0; c < 3000; c++) begin
            bit   ready, take, from_fifo, from_pipe;
            ent_t g;
            case ((c / 300) % 4)
               0: pprob = 95;
               1: pprob = 50;
               2: pprob = 100;
               default: pprob = 10;
            endcase
            // Pipe holds stage 5 while stalled; LU holds its result until accepted
            if (!m_stall) begin
               pipe_wb_valid = ($urandom_range(0, 99) < pprob);
               pipe_rd       = 5'($urandom_range(0, 31));
               pipe_data     = $urandom;
            end
            if (!lu_valid || lu_taken) begin
               lu_valid = ($urandom_range(0, 99) < 45);
               lu_rd    = 5'($urandom_range(0, 31));
               lu_data  = $urandom;
            end

            ready     = (q.size() < DEPTH);
            take      = lu_valid && ready;
            from_fifo = 0;
            from_pipe = 0;
            if (m_stall)
               from_fifo = (q.size() > 0);
            else if (pipe_wb_valid)
               from_pipe = 1;
            else if (q.size() > 0)
               from_fifo = 1;

            if (from_fifo || q.size() == 0) begin
               m_wait  = 0;
               m_stall = 0;
            end else begin
               m_wait++;
               m_stall = (m_wait == STARVE_LIMIT);
               if (m_stall) m_wait = 0;
            end

            if (from_fifo) g = q.pop_front();
            else           g = {pipe_rd, pipe_data};
            if (take) q.push_back({lu_rd, lu_data});
            lu_taken = take;

            if (from_fifo || from_pipe) begin
               e_we = (g.rd != 0);
               e_wa = g.rd;
               e_wd = g.data;
            end else begin
               e_we = 0;
            end

            tick();
            check($sformatf("rnd%0d_we", c),    rf_we,      e_we);
            check($sformatf("rnd%0d_waddr", c), rf_waddr,   e_wa);
            check($sformatf("rnd%0d_wdata", c), rf_wdata,   e_wd);
            check($sformatf("rnd%0d_stall", c), stall_pipe, m_stall);
            check($sformatf("rnd%0d_count", c), fifo_count, q.size());
            check($sformatf("rnd%0d_ready", c), lu_ready,   (q.size() < DEPTH));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Controls the single register-file write port after the writeback stage.
- Shares the port between two requesters:
  - the in-order ALU pipeline writeback (stage 5);
  - a long-latency unit (LU, e.g. mul/div), which delivers through a valid/ready handshake.
- LU results are held in a small FIFO. The pipeline has priority; an anti-starvation counter stalls the pipeline for one cycle to drain a waiting LU result.
- All register-file write outputs are registered.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, LU result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive cycles a nonempty FIFO may go ungranted before a forced drain; at least 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pipe_wb_valid  in  1  stage-5 write request (WriteBack_5).
- pipe_rd  in  ADDR_W  stage-5 destination register.
- pipe_data  in  DATA_W  stage-5 writeback data.
- lu_valid  in  1  LU result valid.
- lu_rd  in  ADDR_W  LU destination register.
- lu_data  in  DATA_W  LU result data.
- lu_ready  out  1  FIFO can accept; equals (not full) and (not rst).
- stall_pipe  out  1  registered; while 1 the pipeline holds stage 5 stable and pipe_wb_valid is ignored.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0.
  - FIFO empty, fifo_count=0, state=NORMAL, wait_cnt=0.
  - lu_ready=0 while rst is high.
  - Any in-flight FIFO contents are discarded; reset mid-operation drops pending LU results.
- FIFO:
  - Enqueue when lu_valid and lu_ready.
  - Dequeue when the FIFO head is granted.
  - Enqueue and dequeue in the same cycle leaves the count unchanged.
  - When full, lu_ready=0 even if a dequeue occurs that cycle; there is no full-bypass.
  - When empty, an arriving LU result cannot be granted in its arrival cycle; there is no empty-bypass.
- State NORMAL (stall_pipe=0):
  - If pipe_wb_valid: grant pipe.
  - Else if FIFO nonempty: grant FIFO head.
  - Otherwise no grant.
- State STALL (stall_pipe=1):
  - Grant FIFO head unconditionally (the FIFO is guaranteed nonempty).
  - pipe_wb_valid is ignored.
  - Next state is NORMAL.
- wait_cnt:
  - Reset to 0 on a FIFO grant or while the FIFO is empty.
  - Increments each NORMAL cycle in which the FIFO is nonempty and the pipe is granted.
  - If it would reach STARVE_LIMIT: next state is STALL and wait_cnt is set to 0.
- Write output (every cycle, next edge):
  - rf_we = granted and (granted rd != 0).
  - rf_waddr and rf_wdata take the granted rd and data.
  - With no grant, rf_we=0 and address/data hold their previous values.
  - A request to x0 is consumed (dequeued/accepted) but produces rf_we=0.
- Latency:
  - Pipe request in cycle N: rf_we is visible in cycle N+1.
  - LU handshake in cycle N: earliest rf_we in cycle N+2.
- Ordering:
  - FIFO is strict FIFO.
  - No WAW checking between pipe and LU; the upstream scoreboard guarantees no younger pipe write targets an rd pending in the LU/FIFO.

Test Plan:
- Reset then idle:
  - Expect rf_we=0, lu_ready=1, stall_pipe=0, fifo_count=0.
  - Assert rst mid-stream with 2 entries queued: fifo_count drops to 0 immediately, and no queued write ever appears.
- Pipe only:
  - pipe_rd=5, data=0xDEADBEEF in cycle N: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1.
  - pipe_rd=0: rf_we stays 0.
- LU only:
  - lu_rd=7, data=0x12345678 handshake in cycle N: fifo_count=1 in N+1, then rf_we=1, waddr=7 in N+2.
  - Two back-to-back LU results drain in order.
- Backpressure:
  - Pipe valid every cycle; 3 LU results offered.
  - After 2 enqueues lu_ready=0 and the third is held until space frees.
  - No result is lost or duplicated.
- Starvation (STARVE_LIMIT=4):
  - Pipe valid every cycle; one LU entry (rd=9) enqueued.
  - After 4 pipe grants, stall_pipe=1 for exactly one cycle.
  - rd=9 is written in the following cycle.
  - The held pipe instruction is written once stall_pipe returns to 0.
- Simultaneous full enqueue/dequeue:
  - FIFO full, pipe idle, lu_valid=1: head dequeues and lu_ready stays 0 that cycle.
  - lu_ready=1 in the next cycle.
